// File: rtl/uart_pkg.sv
// Shared definitions for the tick-driven UART transmitter.
// Latency: none. This package holds only types, constants and a helper.
// Backpressure: not applicable.
package uart_pkg;

    // Transmitter state machine encoding
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Parity mode selectors
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Number of baud-tick periods in one frame, counted from the start-bit edge
    function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by an external baud tick: LSB-first start/data/parity/stop frames.
// Latency: start bit begins on the first BaudTick strictly after the DataValid/DataReady edge.
// Backpressure: DataReady is low from the accepting edge until the final stop period ends.
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 BaudTick,
    input  logic [DATA_BITS-1:0] DataIn,
    input  logic                 DataValid,
    output logic                 DataReady,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 Done
);

    // Reject unsupported configurations at elaboration time
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_tick: DATA_BITS must be in 5..9");
        end
        if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_tick: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_tick: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int             BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 parity_bit;

    // Frame sequencer: every output is a register; only IDLE->SYNC ignores the tick
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            Tx         <= 1'b1;
            DataReady  <= 1'b1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Ticks are irrelevant here; the byte is taken on the handshake alone
                    if (DataValid && DataReady) begin
                        shift_reg  <= DataIn;
                        parity_bit <= (PARITY == PARITY_ODD) ? ~^DataIn : ^DataIn;
                        DataReady  <= 1'b0;
                        Busy       <= 1'b1;
                        state      <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    // Wait for a tick so the start bit lasts a whole bit period
                    if (BaudTick) begin
                        Tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (BaudTick) begin
                        Tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (BaudTick) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY != PARITY_NONE) begin
                                Tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                Tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            Tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (BaudTick) begin
                        Tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Done and DataReady rise together so a waiting source can send next cycle
                    if (BaudTick) begin
                        if (stop_cnt == STOP_LAST) begin
                            Done      <= 1'b1;
                            DataReady <= 1'b1;
                            Busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
